tt_sweep_checker: RTL and testbench

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

---
 rtl/tt_sweep_checker.sv | 137 +++++++++++++
 tb/tb_tt_sweep_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// ---------------------------------------------------------------------------
// tt_sweep_checker
//
// Exhaustively sweeps the 16 input combinations (minterms) of an external
// 4-input combinational network, captures its output for each minterm into
// a truth table and compares it bit-by-bit against a golden truth table
// that is latched when the sweep is started.
//
// Each minterm is held on x0..x3 for SETTLE cycles (DRIVE) and then y0 is
// sampled in a single SAMPLE cycle, so one sweep takes 16*(SETTLE+1) cycles
// followed by a one-cycle FINISH, during which done pulses.
//
// Parameters
//   SETTLE        settle cycles per minterm before sampling (1..15)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   start         single-cycle sweep request (accepted only in IDLE)
//   expected_tt   golden truth table, bit m = expected y0 for minterm m
//   x0..x3        registered stimulus to the network, x0 = m[0] .. x3 = m[3]
//   y0            network output
//   busy          sweep in progress (DRIVE or SAMPLE)
//   done          one-cycle pulse at sweep completion
//   tt_out        captured truth table, bit m = y0 sampled for minterm m
//   pass          captured table matched the golden one; valid from done on
//   mismatch_cnt  number of differing bits (0..16)
//   first_fail    lowest mismatching minterm, 0 when there is no mismatch
// ---------------------------------------------------------------------------
module tt_sweep_checker #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected_tt,
    output logic        x0,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    input  logic        y0,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt_out,
    output logic        pass,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DRIVE  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    // Settle counter runs 0..SETTLE-1 inside DRIVE.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    logic [1:0]  state;
    logic [3:0]  m;           // current minterm; also the registered stimulus
    logic [3:0]  settle_cnt;
    logic [15:0] exp_q;       // golden table captured at start
    logic        miss;

    // Sampled output disagrees with the golden bit for the current minterm.
    assign miss = y0 ^ exp_q[m];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            m            <= 4'd0;
            settle_cnt   <= 4'd0;
            exp_q        <= 16'd0;
            tt_out       <= 16'd0;
            pass         <= 1'b0;
            mismatch_cnt <= 5'd0;
            first_fail   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q        <= expected_tt;
                        m            <= 4'd0;
                        settle_cnt   <= 4'd0;
                        tt_out       <= 16'd0;
                        pass         <= 1'b0;
                        mismatch_cnt <= 5'd0;
                        first_fail   <= 4'd0;
                        state        <= DRIVE;
                    end
                end

                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                SAMPLE: begin
                    tt_out[m] <= y0;
                    if (miss) begin
                        mismatch_cnt <= mismatch_cnt + 5'd1;
                        // Count still zero means this is the first miss.
                        if (mismatch_cnt == 5'd0)
                            first_fail <= m;
                    end
                    if (m == 4'd15) begin
                        // pass must already be valid while done is high,
                        // so fold in this last comparison directly.
                        pass  <= (mismatch_cnt == 5'd0) && !miss;
                        m     <= 4'd0;  // stimulus returns to 0 for IDLE
                        state <= FINISH;
                    end else begin
                        m     <= m + 4'd1;
                        state <= DRIVE;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign x0   = m[0];
    assign x1   = m[1];
    assign x2   = m[2];
    assign x3   = m[3];
    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1, start3;
    logic [15:0] exp_tt;
    int          mode;     // network selection for the loopback model
    bit          sel;      // 0: SETTLE=1 instance, 1: SETTLE=3 instance

    logic        a_x0, a_x1, a_x2, a_x3, a_y0, a_busy, a_done, a_pass;
    logic [15:0] a_tt;
    logic [4:0]  a_cnt;
    logic [3:0]  a_ff;
    logic        b_x0, b_x1, b_x2, b_x3, b_y0, b_busy, b_done, b_pass;
    logic [15:0] b_tt;
    logic [4:0]  b_cnt;
    logic [3:0]  b_ff;

    int tests = 0;
    int fails = 0;

    // Network under test: 0 AND(x0,x1), 1 parity, 2 const 0, 3 x3, else const 1
    function automatic logic net(input int md, input logic [3:0] v);
        case (md)
            0:       return v[0] & v[1];
            1:       return ^v;
            2:       return 1'b0;
            3:       return v[3];
            default: return 1'b1;
        endcase
    endfunction

    always_comb a_y0 = net(mode, {a_x3, a_x2, a_x1, a_x0});
    always_comb b_y0 = net(mode, {b_x3, b_x2, b_x1, b_x0});

    tt_sweep_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected_tt(exp_tt),
        .x0(a_x0), .x1(a_x1), .x2(a_x2), .x3(a_x3), .y0(a_y0),
        .busy(a_busy), .done(a_done), .tt_out(a_tt), .pass(a_pass),
        .mismatch_cnt(a_cnt), .first_fail(a_ff)
    );

    tt_sweep_checker #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .expected_tt(exp_tt),
        .x0(b_x0), .x1(b_x1), .x2(b_x2), .x3(b_x3), .y0(b_y0),
        .busy(b_busy), .done(b_done), .tt_out(b_tt), .pass(b_pass),
        .mismatch_cnt(b_cnt), .first_fail(b_ff)
    );

    logic        o_busy, o_done, o_pass;
    logic [15:0] o_tt;
    logic [4:0]  o_cnt;
    logic [3:0]  o_ff, o_x;
    always_comb begin
        if (sel) begin
            o_busy = b_busy; o_done = b_done; o_pass = b_pass;
            o_tt = b_tt; o_cnt = b_cnt; o_ff = b_ff;
            o_x = {b_x3, b_x2, b_x1, b_x0};
        end else begin
            o_busy = a_busy; o_done = a_done; o_pass = a_pass;
            o_tt = a_tt; o_cnt = a_cnt; o_ff = a_ff;
            o_x = {a_x3, a_x2, a_x1, a_x0};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start(input logic [15:0] tt);
        @(posedge clk); #1;
        exp_tt = tt;
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done; optionally
    // re-pulses start (with a different golden table) at cycle restart_at.
    task automatic wait_done(input string tag, input int exp_n, input int restart_at);
        int n;
        int per;
        bit seen;
        n = 0;
        seen = 0;
        per = sel ? 4 : 2;
        while (n < 200 && !seen) begin
            @(negedge clk);
            n++;
            if (restart_at != 0 && n == restart_at) begin
                start3 = 1'b1;
                exp_tt = 16'h0000;
            end else begin
                start3 = 1'b0;
            end
            if (o_done) seen = 1;
            else if (n <= 16 * per) chk({tag, "_x"}, 32'(o_x), 32'((n - 1) / per));
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_n));
        chk({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    endtask

    task automatic chk_res(input string tag, input logic [15:0] tt, input logic p,
                           input logic [4:0] c, input logic [3:0] f);
        chk({tag, "_tt"},   32'(o_tt),   32'(tt));
        chk({tag, "_pass"}, 32'(o_pass), 32'(p));
        chk({tag, "_cnt"},  32'(o_cnt),  32'(c));
        chk({tag, "_ff"},   32'(o_ff),   32'(f));
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; exp_tt = 16'h0;
        mode = 0; sel = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk_res("rst", 16'h0000, 1'b0, 5'd0, 4'd0);
        chk("rst_x", 32'(o_x), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);

        // AND loopback
        mode = 0; pulse_start(16'h8888);
        wait_done("and", 33, 0);
        chk_res("and", 16'h8888, 1'b1, 5'd0, 4'd0);
        @(negedge clk);
        chk("and_done_pulse", 32'(o_done), 32'd0);
        chk("and_hold_tt", 32'(o_tt), 32'h8888);
        chk("and_hold_pass", 32'(o_pass), 32'd1);

        // parity loopback
        mode = 1; pulse_start(16'h6996);
        wait_done("xor", 33, 0);
        chk_res("xor", 16'h6996, 1'b1, 5'd0, 4'd0);

        // all bits wrong
        mode = 2; pulse_start(16'hFFFF);
        wait_done("zero", 33, 0);
        chk_res("zero", 16'h0000, 1'b0, 5'd16, 4'd0);

        // single mismatch at minterm 0, then at minterm 8
        mode = 3; pulse_start(16'hFF01);
        wait_done("x3a", 33, 0);
        chk_res("x3a", 16'hFF00, 1'b0, 5'd1, 4'd0);
        pulse_start(16'hFE00);
        wait_done("x3b", 33, 0);
        chk_res("x3b", 16'hFF00, 1'b0, 5'd1, 4'd8);

        // reset in DRIVE of minterm 7, with start asserted alongside
        mode = 4; pulse_start(16'h0000);
        for (int i = 0; i < 15; i++) @(negedge clk);
        chk("mid_x", 32'(o_x), 32'd7);
        chk("mid_busy", 32'(o_busy), 32'd1);
        chk("mid_tt", 32'(o_tt), 32'h007F);
        chk("mid_cnt", 32'(o_cnt), 32'd7);
        rst = 1'b1; start1 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start1 = 1'b0;
        chk("mrst_busy", 32'(o_busy), 32'd0);
        chk("mrst_done", 32'(o_done), 32'd0);
        chk_res("mrst", 16'h0000, 1'b0, 5'd0, 4'd0);
        chk("mrst_x", 32'(o_x), 32'd0);
        @(negedge clk);
        chk("mrst_start_ignored", 32'(o_busy), 32'd0);
        mode = 0; pulse_start(16'h8888);
        wait_done("after_rst", 33, 0);
        chk_res("after_rst", 16'h8888, 1'b1, 5'd0, 4'd0);

        // SETTLE=3, restart attempt mid-sweep with a different golden table
        sel = 1; mode = 0; pulse_start(16'h8888);
        wait_done("s3", 65, 20);
        chk_res("s3", 16'h8888, 1'b1, 5'd0, 4'd0);
        @(negedge clk);
        chk("s3_idle", 32'(o_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
